// File: rtl/buzzer_ctrl.sv
// buzzer_ctrl: autonomous C-major scale player (C4..C5) driving a piezo
// buzzer with a registered square wave; each note is followed by a silent gap.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_NOTE | tone counter toggles buzzer every HALF[idx] cycles
//   ST_GAP  | buzzer held 0, waiting GAP_CYCLES before the next note
`timescale 1ns/1ps
module buzzer_ctrl #(
  parameter int CLK_HZ      = 10_000_000,
  parameter int NOTE_CYCLES = CLK_HZ / 4,
  parameter int GAP_CYCLES  = CLK_HZ / 100
) (
  input  logic clk,
  input  logic resetn,
  output logic buzzer
);

  // C4 has the longest half-period, so it sizes the tone counter.
  localparam int HALF_MAX = CLK_HZ / (2 * 262);
  localparam int TW       = $clog2(HALF_MAX) + 1;
  localparam int DUR_MAX  = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DW       = $clog2(DUR_MAX) + 1;

  localparam bit            HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_CYCLES - 1);
  // With no gap the GAP state is never entered, so this value is never compared.
  localparam logic [DW-1:0] GAP_LAST  = DW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  typedef enum logic {ST_NOTE, ST_GAP} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [TW-1:0] tone;
  logic [DW-1:0] dur;
  logic [TW-1:0] tone_last;

  function automatic logic [TW-1:0] half_last(input int freq);
    return TW'(CLK_HZ / (2 * freq) - 1);
  endfunction

  // Note ROM: terminal value of the tone counter for the current note.
  always_comb begin
    tone_last = half_last(262);
    case (idx)
      3'd0:    tone_last = half_last(262);
      3'd1:    tone_last = half_last(294);
      3'd2:    tone_last = half_last(330);
      3'd3:    tone_last = half_last(349);
      3'd4:    tone_last = half_last(392);
      3'd5:    tone_last = half_last(440);
      3'd6:    tone_last = half_last(494);
      3'd7:    tone_last = half_last(523);
      default: tone_last = half_last(262);
    endcase
  end

  // Sequencer: note/gap timing, tone generation and registered buzzer drive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_NOTE;
      idx    <= 3'd0;
      tone   <= '0;
      dur    <= '0;
      buzzer <= 1'b0;
    end else begin
      case (state)
        ST_NOTE: begin
          if (dur == NOTE_LAST) begin
            // End of note wins over a coincident toggle: next note starts from 0.
            buzzer <= 1'b0;
            dur    <= '0;
            tone   <= '0;
            if (HAS_GAP) state <= ST_GAP;
            else         idx   <= idx + 3'd1;
          end else begin
            dur <= dur + DW'(1);
            if (tone == tone_last) begin
              tone   <= '0;
              buzzer <= ~buzzer;
            end else begin
              tone <= tone + TW'(1);
            end
          end
        end
        ST_GAP: begin
          buzzer <= 1'b0;
          tone   <= '0;
          if (dur == GAP_LAST) begin
            dur   <= '0;
            idx   <= idx + 3'd1;
            state <= ST_NOTE;
          end else begin
            dur <= dur + DW'(1);
          end
        end
        default: begin
          state  <= ST_NOTE;
          buzzer <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_ctrl.sv
// Directed bench for buzzer_ctrl: four instances with different timing
// parameters share one clock and reset; buzzer history is captured per edge.
`timescale 1ns/1ps
module tb_buzzer_ctrl;

  localparam int NCAP = 1000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic buz_d, buz_a, buz_b, buz_c;

  int tests_run = 0;
  int tests_failed = 0;

  logic hist_d [0:NCAP];
  logic hist_a [0:NCAP];
  logic hist_b [0:NCAP];
  logic hist_c [0:NCAP];

  // Half-periods for CLK_HZ=10_000, worked out by hand.
  int half_tb [8] = '{19, 17, 15, 14, 12, 11, 10, 9};

  always #50 clk = ~clk;

  buzzer_ctrl u_def (.clk(clk), .resetn(resetn), .buzzer(buz_d));
  buzzer_ctrl #(.CLK_HZ(10_000), .NOTE_CYCLES(100), .GAP_CYCLES(20))
    u_a (.clk(clk), .resetn(resetn), .buzzer(buz_a));
  buzzer_ctrl #(.CLK_HZ(10_000), .NOTE_CYCLES(100), .GAP_CYCLES(0))
    u_b (.clk(clk), .resetn(resetn), .buzzer(buz_b));
  buzzer_ctrl #(.CLK_HZ(10_000), .NOTE_CYCLES(1), .GAP_CYCLES(1))
    u_c (.clk(clk), .resetn(resetn), .buzzer(buz_c));

  // Expected buzzer value after edge e (edge 1 = first edge after release).
  function automatic logic model(input int e, input int n, input int g);
    int p, k, j;
    p = n + g;
    k = ((e - 1) / p) % 8;
    j = ((e - 1) % p) + 1;
    if (j >= n) return 1'b0;
    return ((j / half_tb[k]) % 2) == 1;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    #237;
    tests_run++;
    if ({buz_d, buz_a, buz_b, buz_c} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected 0000", {buz_d, buz_a, buz_b, buz_c});
    end
  endtask

  task automatic capture(input int n);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    hist_d[0] = buz_d; hist_a[0] = buz_a; hist_b[0] = buz_b; hist_c[0] = buz_c;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      hist_d[e] = buz_d; hist_a[e] = buz_a; hist_b[e] = buz_b; hist_c[e] = buz_c;
    end
  endtask

  task automatic test_silent();
    int ones_d, ones_c;
    ones_d = 0; ones_c = 0;
    for (int e = 0; e <= 200; e++) begin
      if (hist_d[e] !== 1'b0) ones_d++;
      if (hist_c[e] !== 1'b0) ones_c++;
    end
    tests_run++;
    if (ones_d !== 0) begin
      tests_failed++;
      $display("FAIL default_silent: %0d non-zero samples, expected 0", ones_d);
    end
    tests_run++;
    if (ones_c !== 0) begin
      tests_failed++;
      $display("FAIL tiny_note_silent: %0d non-zero samples, expected 0", ones_c);
    end
  endtask

  task automatic test_first_note();
    int edges [15] = '{18, 19, 37, 38, 56, 57, 75, 76, 94, 95, 99, 100, 120, 136, 137};
    logic exp_v [15] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1};
    int ones;
    for (int i = 0; i < 15; i++) begin
      tests_run++;
      if (hist_a[edges[i]] !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL first_note edge %0d: got %b expected %b", edges[i], hist_a[edges[i]], exp_v[i]);
      end
    end
    ones = 0;
    for (int e = 100; e <= 136; e++) if (hist_a[e] !== 1'b0) ones++;
    tests_run++;
    if (ones !== 0) begin
      tests_failed++;
      $display("FAIL gap_silent: %0d non-zero samples in edges 100..136, expected 0", ones);
    end
  endtask

  task automatic test_wrap();
    int edges [8] = '{848, 849, 857, 858, 939, 940, 978, 979};
    logic exp_v [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    int ones;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (hist_a[edges[i]] !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL wrap edge %0d: got %b expected %b", edges[i], hist_a[edges[i]], exp_v[i]);
      end
    end
    ones = 0;
    for (int e = 940; e <= 978; e++) if (hist_a[e] !== 1'b0) ones++;
    tests_run++;
    if (ones !== 0) begin
      tests_failed++;
      $display("FAIL wrap_silent: %0d non-zero samples in edges 940..978, expected 0", ones);
    end
  endtask

  task automatic test_no_gap();
    int edges [5] = '{99, 100, 101, 116, 117};
    logic exp_v [5] = '{1, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (hist_b[edges[i]] !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL no_gap edge %0d: got %b expected %b", edges[i], hist_b[edges[i]], exp_v[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int bad_a, bad_b, first_a, first_b;
    bad_a = 0; bad_b = 0; first_a = -1; first_b = -1;
    for (int e = 1; e <= NCAP; e++) begin
      if (hist_a[e] !== model(e, 100, 20)) begin
        bad_a++;
        if (first_a < 0) first_a = e;
      end
      if (hist_b[e] !== model(e, 100, 0)) begin
        bad_b++;
        if (first_b < 0) first_b = e;
      end
    end
    tests_run++;
    if (bad_a !== 0) begin
      tests_failed++;
      $display("FAIL sweep_gap20: %0d mismatching edges (first %0d), expected 0", bad_a, first_a);
    end
    tests_run++;
    if (bad_b !== 0) begin
      tests_failed++;
      $display("FAIL sweep_gap0: %0d mismatching edges (first %0d), expected 0", bad_b, first_b);
    end
  endtask

  task automatic test_async_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (57) @(posedge clk);
    #30;
    tests_run++;
    if (buz_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_high: got %b expected 1", buz_a);
    end
    resetn = 1'b0;
    #1;
    tests_run++;
    if (buz_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_immediate: got %b expected 0", buz_a);
    end
    #100;
    @(negedge clk);
    resetn = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    tests_run++;
    if (buz_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_edge18: got %b expected 0", buz_a);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (buz_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_edge19: got %b expected 1", buz_a);
    end
  endtask

  initial begin
    test_reset();
    capture(NCAP);
    test_silent();
    test_first_note();
    test_wrap();
    test_no_gap();
    test_sweep();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
